merge_sort_ctrl: RTL and testbench

//  Sequencer for the 8-way merge-sort datapath. Steers the sort4 quad writes into a

---
 rtl/merge_sort_pkg.sv | 16 +
 rtl/merge_head_tracker.sv | 68 ++++++
 rtl/merge_sort_ctrl.sv | 118 +++++++++++
 tb/tb_merge_sort_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_sort_pkg.sv
// Shared definitions for the 8-way merge-sort datapath, comparator tree and sequencer.
package merge_sort_pkg;

    localparam int NUM_RUNS  = 8;
    localparam int RUN_LEN   = 4;
    localparam int RUN_W     = $clog2(NUM_RUNS);
    localparam int PTR_W     = $clog2(RUN_LEN) + 1;
    localparam int CNT_W     = $clog2(NUM_RUNS * RUN_LEN);
    localparam int GROUP_LEN = NUM_RUNS * RUN_LEN;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } merge_state_e;

endpackage

// File: rtl/merge_head_tracker.sv
// Per-run head pointers for the merge phase, exhausted-run decode and the
// sticky illegal-winner flag. A head pointer saturates at RUN_LEN.
module merge_head_tracker
    import merge_sort_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      fire_i,
    input  logic                      clear_i,
    input  logic [RUN_W-1:0]          win_idx_i,
    output logic [NUM_RUNS*PTR_W-1:0] head_ptr_o,
    output logic [NUM_RUNS-1:0]       run_done_o,
    output logic                      err_win_o
);

    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(RUN_LEN);

    logic [PTR_W-1:0] head_q [NUM_RUNS];
    logic [PTR_W-1:0] head_d [NUM_RUNS];
    logic             err_q;
    logic             err_d;

    // Advance the winner's head on a fire; a winner that is already exhausted raises the error instead.
    always_comb begin
        for (int i = 0; i < NUM_RUNS; i++) begin
            head_d[i] = head_q[i];
        end
        err_d = err_q;
        if (fire_i) begin
            if (head_q[win_idx_i] == PTR_END) begin
                err_d = 1'b1;
            end else begin
                head_d[win_idx_i] = head_q[win_idx_i] + PTR_W'(1);
            end
        end
        if (clear_i) begin
            for (int i = 0; i < NUM_RUNS; i++) begin
                head_d[i] = '0;
            end
        end
    end

    // Head pointer and error registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_RUNS; i++) begin
                head_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RUNS; i++) begin
                head_q[i] <= head_d[i];
            end
            err_q <= err_d;
        end
    end

    // Flatten the pointers and mark runs that the comparator tree must exclude.
    always_comb begin
        for (int i = 0; i < NUM_RUNS; i++) begin
            head_ptr_o[i*PTR_W +: PTR_W] = head_q[i];
            run_done_o[i]                = (head_q[i] == PTR_END);
        end
    end

    assign err_win_o = err_q;

endmodule

// File: rtl/merge_sort_ctrl.sv
// Sequencer for the 8-way merge sort: fills a ping-pong pair of run banks with
// sorted quads and merges the full bank into a valid/ready output stream.
// Reset is synchronous and active-low.
module merge_sort_ctrl
    import merge_sort_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic                      wr_en_o,
    output logic                      wr_bank_o,
    output logic [RUN_W-1:0]          wr_row_o,
    output logic                      rd_bank_o,
    output logic [NUM_RUNS*PTR_W-1:0] head_ptr_o,
    output logic [NUM_RUNS-1:0]       run_done_o,
    input  logic [RUN_W-1:0]          win_idx_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      out_last_o,
    output logic                      err_win_o
);

    logic             wr_bank_q;
    logic [RUN_W-1:0] wr_row_q;
    logic [1:0]       bank_full_q;
    logic [1:0]       bank_full_d;
    logic             rd_bank_q;
    logic [CNT_W-1:0] out_cnt_q;
    merge_state_e     state_q;

    logic             fire;
    logic             beat_last;
    logic             last_fire;
    logic             row_last;

    assign in_ready_o  = rst_i & ~bank_full_q[wr_bank_q];
    assign wr_en_o     = in_valid_i & in_ready_o;
    assign row_last    = (wr_row_q == RUN_W'(NUM_RUNS - 1));
    assign out_valid_o = rst_i & (state_q == MERGE);
    assign beat_last   = (out_cnt_q == CNT_W'(GROUP_LEN - 1));
    assign out_last_o  = out_valid_o & beat_last;
    assign fire        = out_valid_o & out_ready_i;
    assign last_fire   = fire & beat_last;

    assign wr_bank_o   = wr_bank_q;
    assign wr_row_o    = wr_row_q;
    assign rd_bank_o   = rd_bank_q;

    // Filling and merging always touch different banks, so set and clear are both applied.
    always_comb begin
        bank_full_d = bank_full_q;
        if (wr_en_o && row_last) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
        if (last_fire) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
    end

    // Fill side: row counter walks the runs, the bank flips once all runs are written.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_bank_q   <= 1'b0;
            wr_row_q    <= '0;
            bank_full_q <= 2'b00;
        end else begin
            bank_full_q <= bank_full_d;
            if (wr_en_o) begin
                wr_row_q <= wr_row_q + RUN_W'(1);
                if (row_last) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
        end
    end

    // Merge FSM: wait for the read bank to fill, then emit one beat per fire until the group ends.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            rd_bank_q <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bank_full_q[rd_bank_q]) begin
                        state_q <= MERGE;
                    end
                end
                MERGE: begin
                    if (fire) begin
                        if (beat_last) begin
                            state_q   <= IDLE;
                            rd_bank_q <= ~rd_bank_q;
                            out_cnt_q <= '0;
                        end else begin
                            out_cnt_q <= out_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    merge_head_tracker u_heads (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .fire_i     (fire),
        .clear_i    (last_fire),
        .win_idx_i  (win_idx_i),
        .head_ptr_o (head_ptr_o),
        .run_done_o (run_done_o),
        .err_win_o  (err_win_o)
    );

endmodule

// File: tb/tb_merge_sort_ctrl.sv
// Self-checking bench for merge_sort_ctrl. The bench plays the datapath and
// comparator tree (run memory plus argmax winner) and keeps a behavioural model
// of what the sequencer must do, compared against the DUT on every cycle.
module tb_merge_sort_ctrl;
    import merge_sort_pkg::*;

    logic                      clk      = 1'b0;
    logic                      rst      = 1'b0;
    logic                      inValid  = 1'b0;
    logic                      outReady = 1'b0;
    logic [RUN_W-1:0]          winIdx;
    logic                      inReady, wrEn, wrBank, rdBank, outValid, outLast, errWin;
    logic [RUN_W-1:0]          wrRow;
    logic [NUM_RUNS*PTR_W-1:0] headPtr;
    logic [NUM_RUNS-1:0]       runDone;

    int total = 0;
    int bad   = 0;

    int         mem [2][NUM_RUNS][RUN_LEN];
    int         quad [RUN_LEN];
    logic       forceWin  = 1'b0;
    logic [RUN_W-1:0] forcedIdx = '0;
    bit         checkData = 1'b1;
    int         readyPct  = 100;
    int         bestVal;

    int  mWrBank, mWrRow, mRdBank, mCnt;
    bit  mFull [2];
    bit  mMerge, mErr;
    int  mHead [NUM_RUNS];
    int  grpVals[$];
    int  expQ[$];

    bit  started     = 1'b0;
    bit  prevValid   = 1'b0;
    int  cycle       = 0;
    int  lastWrCycle = 0;
    int  firstGap    = -1;
    int  grpFires    = 0;
    int  lastAt      = 0;
    int  lasts       = 0;
    int  stalls      = 0;

    always #5 clk = ~clk;

    merge_sort_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .wr_en_o     (wrEn),
        .wr_bank_o   (wrBank),
        .wr_row_o    (wrRow),
        .rd_bank_o   (rdBank),
        .head_ptr_o  (headPtr),
        .run_done_o  (runDone),
        .win_idx_i   (winIdx),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .out_last_o  (outLast),
        .err_win_o   (errWin)
    );

    // Comparator tree stand-in: largest head value among live runs, lowest index on ties.
    always_comb begin
        bestVal = -1;
        winIdx  = '0;
        for (int i = 0; i < NUM_RUNS; i++) begin
            if (!runDone[i] && int'(headPtr[i*PTR_W +: PTR_W]) < RUN_LEN) begin
                if (mem[rdBank][i][headPtr[i*PTR_W +: PTR_W]] > bestVal) begin
                    bestVal = mem[rdBank][i][headPtr[i*PTR_W +: PTR_W]];
                    winIdx  = RUN_W'(i);
                end
            end
        end
        if (forceWin) winIdx = forcedIdx;
    end

    function automatic int headOf(input int r);
        return int'(headPtr[r*PTR_W +: PTR_W]);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Compare every DUT output with the model, then step the model using this cycle's inputs.
    always @(negedge clk) begin
        bit wrExp, fire, start;
        int w, got;
        int srt[$];
        cycle++;
        if (started) begin
            wrExp = rst && inValid && !mFull[mWrBank];
            fire  = rst && mMerge && outReady;
            start = rst && !mMerge && mFull[mRdBank];
            checkOutput("in_ready",  int'(inReady),  int'(rst && !mFull[mWrBank]));
            checkOutput("wr_en",     int'(wrEn),     int'(wrExp));
            checkOutput("wr_bank",   int'(wrBank),   mWrBank);
            checkOutput("wr_row",    int'(wrRow),    mWrRow);
            checkOutput("rd_bank",   int'(rdBank),   mRdBank);
            checkOutput("out_valid", int'(outValid), int'(rst && mMerge));
            checkOutput("out_last",  int'(outLast),  int'(rst && mMerge && mCnt == GROUP_LEN - 1));
            checkOutput("err_win",   int'(errWin),   int'(mErr));
            for (int i = 0; i < NUM_RUNS; i++) begin
                checkOutput($sformatf("head_ptr[%0d]", i), headOf(i), mHead[i]);
                checkOutput($sformatf("run_done[%0d]", i), int'(runDone[i]), int'(mHead[i] == RUN_LEN));
            end

            if (outValid && !prevValid) firstGap = cycle - lastWrCycle;
            if (inValid && !inReady) stalls++;
            if (outValid && outReady) begin
                grpFires++;
                if (outLast) begin
                    lastAt   = grpFires;
                    lasts++;
                    grpFires = 0;
                end
            end
            prevValid = outValid;

            if (fire) begin
                got = (headOf(int'(winIdx)) < RUN_LEN) ? mem[rdBank][winIdx][headOf(int'(winIdx))] : -1;
                if (expQ.size() == 0) begin
                    checkOutput("merged_data_available", 0, 1 - int'(checkData) + 1);
                end else begin
                    w = expQ.pop_front();
                    if (checkData) checkOutput("merged_data", got, w);
                end
            end

            if (wrExp) begin
                for (int k = 0; k < RUN_LEN; k++) grpVals.push_back(quad[k]);
                if (mWrRow == NUM_RUNS - 1) begin
                    srt = grpVals;
                    srt.rsort();
                    foreach (srt[k]) expQ.push_back(srt[k]);
                    grpVals.delete();
                    mFull[mWrBank] = 1'b1;
                    mWrBank        = mWrBank ^ 1;
                    mWrRow         = 0;
                    lastWrCycle    = cycle;
                end else begin
                    mWrRow++;
                end
            end
            if (fire) begin
                w = int'(winIdx);
                if (mHead[w] == RUN_LEN) mErr = 1'b1;
                else mHead[w]++;
                if (mCnt == GROUP_LEN - 1) begin
                    mFull[mRdBank] = 1'b0;
                    mRdBank        = mRdBank ^ 1;
                    mCnt           = 0;
                    mMerge         = 1'b0;
                    foreach (mHead[i]) mHead[i] = 0;
                end else begin
                    mCnt++;
                end
            end
            if (start) mMerge = 1'b1;
        end

        if (wrEn) begin
            for (int k = 0; k < RUN_LEN; k++) mem[wrBank][wrRow][k] = quad[k];
        end

        if (!rst) begin
            mWrBank = 0; mWrRow = 0; mRdBank = 0; mCnt = 0;
            mFull[0] = 1'b0; mFull[1] = 1'b0;
            mMerge = 1'b0; mErr = 1'b0;
            foreach (mHead[i]) mHead[i] = 0;
            grpVals.delete();
            expQ.delete();
            grpFires  = 0;
            prevValid = 1'b0;
            started   = 1'b1;
        end
    end

    // Downstream acceptance, redrawn every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            outReady = (readyPct >= 100) ? 1'b1 : ($urandom_range(0, 99) < readyPct);
        end
    end

    task automatic newQuad();
        int q[$];
        for (int k = 0; k < RUN_LEN; k++) q.push_back(int'($urandom_range(0, 255)));
        q.rsort();
        for (int k = 0; k < RUN_LEN; k++) quad[k] = q[k];
    endtask

    // Offer nQuads sorted quads upstream, each held until accepted.
    task automatic applyStimulus(input int nQuads);
        int n;
        for (int q = 0; q < nQuads; q++) begin
            newQuad();
            inValid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!wrEn && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (!wrEn) begin
                checkOutput("quad_accept", int'(wrEn), 1);
                inValid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
    endtask

    task automatic waitLasts(input int target);
        int n = 0;
        while (lasts < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("groups_completed", lasts, target);
    endtask

    task automatic waitFires(input int target);
        int n = 0;
        while (grpFires < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("fires_reached", grpFires, target);
    endtask

    initial begin
        int base;
        int stallBase;

        // Reset held with upstream valid.
        rst     = 1'b0;
        inValid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", int'(inReady), 0);
        checkOutput("reset_wr_en", int'(wrEn), 0);
        checkOutput("reset_out_valid", int'(outValid), 0);
        inValid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", int'(inReady), 1);
        checkOutput("release_wr_bank", int'(wrBank), 0);
        checkOutput("release_wr_row", int'(wrRow), 0);
        @(posedge clk);
        #1;

        // Single group at full throughput.
        readyPct = 100;
        base = lasts;
        applyStimulus(8);
        waitLasts(base + 1);
        checkOutput("single_first_valid_gap", firstGap, 2);
        checkOutput("single_last_beat", lastAt, 32);
        checkOutput("single_rd_bank_after", int'(rdBank), 1);
        checkOutput("single_idle_after", int'(outValid), 0);

        // Three groups streamed back to back.
        base      = lasts;
        stallBase = stalls;
        applyStimulus(24);
        waitLasts(base + 3);
        checkOutput("pingpong_stalled", int'(stalls > stallBase), 1);
        checkOutput("pingpong_rd_bank_after", int'(rdBank), 0);

        // Random downstream back-pressure.
        readyPct = 50;
        base = lasts;
        applyStimulus(16);
        waitLasts(base + 2);
        checkOutput("backpressure_last_beat", lastAt, 32);
        readyPct = 100;

        // Comparator repeatedly picks run 3.
        forcedIdx = RUN_W'(3);
        forceWin  = 1'b1;
        checkData = 1'b0;
        base = lasts;
        applyStimulus(8);
        waitFires(5);
        forceWin = 1'b0;
        checkOutput("illegal_err_win", int'(errWin), 1);
        checkOutput("illegal_head3", headOf(3), 4);
        waitLasts(base + 1);
        checkOutput("illegal_last_beat", lastAt, 32);
        checkOutput("illegal_err_sticky", int'(errWin), 1);
        checkData = 1'b1;

        // Reset in the middle of a merge, then a fresh group.
        applyStimulus(8);
        waitFires(10);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset_out_valid", int'(outValid), 0);
        checkOutput("midreset_head_ptr", int'(headPtr != '0), 0);
        checkOutput("midreset_err_win", int'(errWin), 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_in_ready", int'(inReady), 1);
        @(posedge clk);
        #1;
        base = lasts;
        applyStimulus(8);
        waitLasts(base + 1);
        checkOutput("fresh_first_valid_gap", firstGap, 2);
        checkOutput("fresh_last_beat", lastAt, 32);
        checkOutput("fresh_rd_bank_after", int'(rdBank), 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
